// File: rtl/serial_tx.sv
// Byte-wide asynchronous serial transmitter. A one-byte holding register sits
// in front of the shift engine so the next character can queue mid-frame.
module serial_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       cereal,
  output logic       status,
  output logic       busy
);
  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY == 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state, state_nx;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic          stop_cnt, stop_cnt_nx;
  logic [7:0]    shift, shift_nx, hold;
  logic          par, par_nx;
  logic          bit_end, load, accept, line_nx;

  assign bit_end = (baud == BAUD_MAX);
  assign accept  = start && !status;

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    stop_cnt_nx = stop_cnt;
    shift_nx    = shift;
    par_nx      = par;
    load        = 1'b0;
    case (state)
      S_IDLE:  if (status) load = 1'b1;
      S_START: if (bit_end) state_nx = S_DATA;
      S_DATA:
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_nx = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            shift_nx   = shift >> 1;
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      S_PAR:   if (bit_end) state_nx = S_STOP;
      S_STOP:
        if (bit_end) begin
          // Last stop cycle: chain straight into the queued byte when present.
          if (stop_cnt == STOP_LAST) begin
            if (status) load = 1'b1;
            else        state_nx = S_IDLE;
          end else begin
            stop_cnt_nx = 1'b1;
          end
        end
      default: state_nx = S_IDLE;
    endcase
    if (load) begin
      state_nx    = S_START;
      shift_nx    = hold;
      par_nx      = (^hold) ^ ODD;
      bit_cnt_nx  = 3'd0;
      stop_cnt_nx = 1'b0;
    end
  end

  always_comb begin
    line_nx = 1'b1;
    case (state_nx)
      S_START: line_nx = 1'b0;
      S_DATA:  line_nx = shift_nx[0];
      S_PAR:   line_nx = par_nx;
      default: line_nx = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      shift    <= 8'd0;
      par      <= 1'b0;
      hold     <= 8'd0;
      status   <= 1'b0;
      busy     <= 1'b0;
      cereal   <= 1'b1;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      stop_cnt <= stop_cnt_nx;
      shift    <= shift_nx;
      par      <= par_nx;
      // Baud count restarts on every bit boundary and every state entry.
      if (bit_end || state_nx == S_IDLE || state_nx != state) baud <= '0;
      else                                                     baud <= baud + 1'b1;
      if (load) begin
        status <= 1'b0;
      end else if (accept) begin
        status <= 1'b1;
        hold   <= data;
      end
      busy   <= (state_nx != S_IDLE);
      cereal <= line_nx;
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four instances (no parity, even, odd, two stop bits),
// a line decoder per instance against a byte scoreboard, plus cycle checks.
module tb_serial_tx;
  localparam int C    = 4;
  localparam int NDUT = 4;

  logic                 sysclk;
  logic                 rst_n;
  logic [NDUT-1:0][7:0] data;
  logic [NDUT-1:0]      start;
  logic [NDUT-1:0]      cereal;
  logic [NDUT-1:0]      status;
  logic [NDUT-1:0]      busy;

  int         checks = 0;
  int         errors = 0;
  int         rst_events = 0;
  logic [7:0] exp_q [NDUT][$];

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  always @(negedge rst_n) rst_events++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while ((busy[g] || status[g]) && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("u%0d idle within budget", g), (n < 300), 1);
    repeat (3) tick();
  endtask

  function automatic logic [9:0] frame10(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int P  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    localparam int S  = (g == 3) ? 2 : 1;
    localparam int NB = 10 + ((P != 0) ? 1 : 0) + (S - 1);

    serial_tx #(.CLKS_PER_BIT(C), .PARITY(P), .STOP_BITS(S)) u_dut (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .data  (data[g]),
      .start (start[g]),
      .cereal(cereal[g]),
      .status(status[g]),
      .busy  (busy[g])
    );

    // Decoder: on a start edge sample each bit mid-cell, then score the frame.
    initial begin : mon
      logic [11:0] fr;
      logic [7:0]  e;
      int          r0;
      forever begin
        @(posedge sysclk);
        #1;
        if (rst_n === 1'b1 && cereal[g] === 1'b0) begin
          r0 = rst_events;
          fr = '0;
          repeat (C / 2) @(posedge sysclk);
          #1;
          fr[0] = cereal[g];
          for (int k = 1; k < NB; k++) begin
            repeat (C) @(posedge sysclk);
            #1;
            fr[k] = cereal[g];
          end
          repeat (C - C / 2 - 1) @(posedge sysclk);
          if (rst_events == r0) begin
            chk($sformatf("u%0d frame has queued byte", g), (exp_q[g].size() > 0), 1);
            if (exp_q[g].size() > 0) begin
              e = exp_q[g].pop_front();
              chk($sformatf("u%0d start bit", g), fr[0], 0);
              chk($sformatf("u%0d data byte", g), fr[8:1], e);
              if (P != 0) chk($sformatf("u%0d parity", g), fr[9], (^e) ^ (P == 2));
              chk($sformatf("u%0d stop bit", g), fr[NB-1], 1);
              chk($sformatf("u%0d first stop bit", g), fr[NB-S], 1);
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0] d;
    logic [9:0] line;
  } vec_t;

  vec_t       vt[5];
  logic [9:0] fa, fb;

  initial begin
    vt[0] = '{8'hA5, 10'b1101001010};
    vt[1] = '{8'h00, 10'b1000000000};
    vt[2] = '{8'hFF, 10'b1111111110};
    vt[3] = '{8'h3C, 10'b1001111000};
    vt[4] = '{8'h81, 10'b1100000010};

    rst_n = 1'b0;
    start = '0;
    data  = '0;
    repeat (3) @(posedge sysclk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("u%0d reset cereal", g), cereal[g], 1);
      chk($sformatf("u%0d reset status", g), status[g], 0);
      chk($sformatf("u%0d reset busy", g), busy[g], 0);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // Single-byte frames on the idle no-parity engine.
    for (int i = 0; i < 5; i++) begin
      data[0] = vt[i].d;
      start[0] = 1'b1;
      exp_q[0].push_back(vt[i].d);
      tick();
      start[0] = 1'b0;
      chk("wr status", status[0], 1);
      chk("wr busy", busy[0], 0);
      chk("wr cereal", cereal[0], 1);
      for (int s = 1; s <= 40; s++) begin
        tick();
        chk($sformatf("vec%0d line s%0d", i, s), cereal[0], vt[i].line[(s-1)/4]);
        chk($sformatf("vec%0d busy s%0d", i, s), busy[0], 1);
        chk($sformatf("vec%0d status s%0d", i, s), status[0], 0);
      end
      tick();
      chk("vec busy fall", busy[0], 0);
      chk("vec idle line", cereal[0], 1);
      repeat (2) tick();
    end

    // Back-to-back: second byte written as soon as status drops.
    fa = frame10(8'h55);
    fb = frame10(8'h0F);
    data[0] = 8'h55;
    start[0] = 1'b1;
    exp_q[0].push_back(8'h55);
    tick();
    start[0] = 1'b0;
    for (int s = 1; s <= 80; s++) begin
      tick();
      chk($sformatf("b2b line s%0d", s), cereal[0], (s <= 40) ? fa[(s-1)/4] : fb[(s-41)/4]);
      chk($sformatf("b2b busy s%0d", s), busy[0], 1);
      chk($sformatf("b2b status s%0d", s), status[0], (s >= 2 && s <= 40));
      if (s == 1) begin
        data[0] = 8'h0F;
        start[0] = 1'b1;
        exp_q[0].push_back(8'h0F);
      end
      if (s == 2) start[0] = 1'b0;
    end
    tick();
    chk("b2b busy fall", busy[0], 0);
    wait_idle(0);

    // Overrun: 0xFF written while a byte is queued must be dropped.
    data[0] = 8'h11;
    start[0] = 1'b1;
    exp_q[0].push_back(8'h11);
    tick();
    start[0] = 1'b0;
    tick();
    data[0] = 8'h22;
    start[0] = 1'b1;
    exp_q[0].push_back(8'h22);
    tick();
    data[0] = 8'hFF;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("ovr status held", status[0], 1);
    end
    start[0] = 1'b0;
    wait_idle(0);

    // Write landing on the last stop cycle: exactly one idle-high cycle.
    data[0] = 8'h81;
    start[0] = 1'b1;
    exp_q[0].push_back(8'h81);
    tick();
    start[0] = 1'b0;
    for (int s = 1; s <= 40; s++) tick();
    chk("last-stop busy", busy[0], 1);
    data[0] = 8'h3C;
    start[0] = 1'b1;
    exp_q[0].push_back(8'h3C);
    tick();
    start[0] = 1'b0;
    chk("gap cereal", cereal[0], 1);
    chk("gap busy", busy[0], 0);
    chk("gap status", status[0], 1);
    tick();
    chk("gap load cereal", cereal[0], 0);
    chk("gap load busy", busy[0], 1);
    chk("gap load status", status[0], 0);
    wait_idle(0);

    // Even (u1) and odd (u2) parity on 0x07.
    data[1] = 8'h07;
    data[2] = 8'h07;
    start[1] = 1'b1;
    start[2] = 1'b1;
    exp_q[1].push_back(8'h07);
    exp_q[2].push_back(8'h07);
    tick();
    start[1] = 1'b0;
    start[2] = 1'b0;
    for (int s = 1; s <= 45; s++) begin
      tick();
      for (int j = 1; j <= 2; j++) begin
        chk($sformatf("par u%0d busy s%0d", j, s), busy[j], (s <= 44));
        if (s >= 37 && s <= 40) chk($sformatf("par u%0d bit s%0d", j, s), cereal[j], (j == 1));
      end
    end
    wait_idle(1);
    wait_idle(2);

    // Two stop bits (u3): 0x00 followed by a queued 0xAA.
    data[3] = 8'h00;
    start[3] = 1'b1;
    exp_q[3].push_back(8'h00);
    tick();
    start[3] = 1'b0;
    for (int s = 1; s <= 45; s++) begin
      tick();
      if (s == 1) begin
        data[3] = 8'hAA;
        start[3] = 1'b1;
        exp_q[3].push_back(8'hAA);
      end
      if (s == 2) start[3] = 1'b0;
      if (s >= 33 && s <= 36) chk($sformatf("2stop d7 s%0d", s), cereal[3], 0);
      if (s >= 37 && s <= 44) chk($sformatf("2stop high s%0d", s), cereal[3], 1);
      if (s == 45) chk("2stop next start", cereal[3], 0);
      chk($sformatf("2stop busy s%0d", s), busy[3], 1);
    end
    wait_idle(3);

    // Reset during data bit 3 with a byte queued.
    data[0] = 8'h5A;
    start[0] = 1'b1;
    exp_q[0].push_back(8'h5A);
    tick();
    start[0] = 1'b0;
    tick();
    data[0] = 8'hC3;
    start[0] = 1'b1;
    exp_q[0].push_back(8'hC3);
    tick();
    start[0] = 1'b0;
    repeat (16) tick();
    chk("rst pre status", status[0], 1);
    chk("rst pre busy", busy[0], 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst cereal", cereal[0], 1);
    chk("rst busy", busy[0], 0);
    chk("rst status", status[0], 0);
    exp_q[0].delete();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int s = 0; s < 60; s++) begin
      tick();
      chk($sformatf("post-rst line s%0d", s), cereal[0], 1);
      chk($sformatf("post-rst busy s%0d", s), busy[0], 0);
    end

    for (int g = 0; g < NDUT; g++)
      chk($sformatf("u%0d scoreboard drained", g), exp_q[g].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=done");
    $fatal(1, "watchdog");
  end
endmodule
